drum_step_sequencer: RTL and testbench
======================================

Name: drum_step_sequencer

Overview:
Transport and step scheduler for the drum machine. It divides the system clock into step periods and walks a step position from 0 to len_i-1, wrapping at the end. At each step it fires one-cycle trigger pulses for every track whose pattern bit is set at that step. It owns the pattern store, which is written through a simple write port. Downstream voice/sample blocks consume trig_o; the UI/display consumes step_o and running_o.

Parameters:
TRACKS, 4, number of drum tracks (trigger outputs)
STEP_W, 4, step index width; maximum pattern length 2**STEP_W
DIV_W, 24, width of the clock-cycles-per-step divider

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start_i  input  1  pulse: start from step 0, or resume from pause
stop_i  input  1  pulse: stop and return to step 0
pause_i  input  1  pulse: toggle pause while playing
div_i  input  DIV_W  clock cycles per step; 0 or 1 means one step per cycle
len_i  input  STEP_W  pattern length n, steps 0..n-1; 0 means 2**STEP_W
pat_we_i  input  1  pattern write enable
pat_track_i  input  $clog2(TRACKS)  pattern write track index
pat_step_i  input  STEP_W  pattern write step index
pat_val_i  input  1  pattern bit to write
step_o  output  STEP_W  current step position
step_stb_o  output  1  one-cycle strobe at every step boundary, including the start of step 0
trig_o  output  TRACKS  one-cycle per-track triggers, coincident with step_stb_o
running_o  output  1  high in RUN and PAUSED

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset state: FSM = IDLE, step_o = 0, tick counter = 0, step_stb_o = 0, trig_o = 0, running_o = 0, all pattern bits = 0.
- FSM states are IDLE, RUN and PAUSED. Control priority is stop_i > start_i > pause_i.
- IDLE:
  - start_i -> RUN.
  - On the next cycle: step_o = 0, step_stb_o = 1, trig_o = pattern[*][0]. Latency is 1 cycle.
- RUN:
  - The tick counter counts 0..div-1.
  - When tick >= div-1 (div_i <= 1 means every cycle): tick -> 0, step advances, step_stb_o = 1, trig_o = pattern[*][new step], all registered.
  - Step period is exactly max(div_i, 1) cycles.
- Step wrap: if step_o >= eff_len-1, the next step is 0; otherwise step+1. eff_len = len_i, or 2**STEP_W when len_i = 0. The >= handles len_i shrinking below the current step.
- Live controls: div_i and len_i are sampled live every cycle. No latching.
- start_i in RUN: restart. Next cycle: step_o = 0, tick = 0, strobe and trigger for step 0.
- pause_i in RUN -> PAUSED:
  - tick and step hold; no strobes or triggers.
  - pause_i or start_i in PAUSED -> RUN. This resumes from the held tick with no re-trigger of the current step.
- stop_i in any state -> IDLE next cycle: step_o = 0, tick = 0, no strobe, trig_o = 0.
- Outputs: step_stb_o and trig_o are never high outside the single boundary cycle. trig_o is always 0 when step_stb_o = 0.
- Pattern writes:
  - A write takes effect at the next clock edge and is legal in any state.
  - If a write targets the step being triggered in the same cycle, the trigger uses the old value (read-before-write).
  - Out-of-range pat_track_i (>= TRACKS) is ignored.
- Storage: registers, TRACKS x 2**STEP_W bits, combinationally readable.

Test Plan:
- Reset: assert rst_n = 0 mid-RUN at step 5 -> all outputs go 0 immediately (asynchronous). Release, then start_i -> step 0 strobe 1 cycle later.
- Basic play: div_i = 4, len_i = 4, track0 pattern 1010, track1 pattern 0001, start_i -> strobes 4 cycles apart; step_o 0,1,2,3,0.
  - trig_o[0] fires at steps 0 and 2.
  - trig_o[1] fires at step 3.
  - No triggers between strobes.
- Boundary divider and length:
  - div_i = 0 -> strobe every cycle.
  - len_i = 0 -> step_o reaches 15 then wraps to 0.
  - len_i changed from 8 to 3 while at step 6 -> next step 0.
- Pause/resume: div_i = 10, pause_i 3 cycles into step 2, hold 20 cycles, then start_i -> no strobes while paused; step 3 strobe exactly 7 cycles after resume.
- Priority and restart:
  - stop_i and start_i in the same cycle -> IDLE, running_o = 0.
  - start_i at step 5 in RUN -> next cycle step_o = 0 with step-0 triggers.
- Write collision: write track2 step 1 = 1 in the same cycle as the step-1 boundary register update -> no trigger this pass; trigger on the next pass through step 1.

Source files
------------

// File: rtl/drum_step_sequencer_if.sv
// Drum step sequencer bus: transport controls, pattern write port
// and step/trigger outputs.
interface drum_step_sequencer_if #(
  parameter int TRACKS = 4,
  parameter int STEP_W = 4,
  parameter int DIV_W  = 24
);
  localparam int TW = $clog2(TRACKS);

  logic              start_i;
  logic              stop_i;
  logic              pause_i;
  logic [DIV_W-1:0]  div_i;
  logic [STEP_W-1:0] len_i;
  logic              pat_we_i;
  logic [TW-1:0]     pat_track_i;
  logic [STEP_W-1:0] pat_step_i;
  logic              pat_val_i;
  logic [STEP_W-1:0] step_o;
  logic              step_stb_o;
  logic [TRACKS-1:0] trig_o;
  logic              running_o;

  modport master (
    output start_i,
    output stop_i,
    output pause_i,
    output div_i,
    output len_i,
    output pat_we_i,
    output pat_track_i,
    output pat_step_i,
    output pat_val_i,
    input  step_o,
    input  step_stb_o,
    input  trig_o,
    input  running_o
  );

  modport slave (
    input  start_i,
    input  stop_i,
    input  pause_i,
    input  div_i,
    input  len_i,
    input  pat_we_i,
    input  pat_track_i,
    input  pat_step_i,
    input  pat_val_i,
    output step_o,
    output step_stb_o,
    output trig_o,
    output running_o
  );
endinterface

// File: rtl/drum_step_sequencer.sv
// Drum machine transport: divides clk into steps, walks the pattern
// and fires one-cycle per-track triggers at each step boundary.
module drum_step_sequencer #(
  parameter int TRACKS = 4,
  parameter int STEP_W = 4,
  parameter int DIV_W  = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  drum_step_sequencer_if.slave  bus
);
  localparam int TW    = $clog2(TRACKS);
  localparam int NSTEP = 2**STEP_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } state_e;

  state_e                         state_q, state_d;
  logic [STEP_W-1:0]              step_q, step_d;
  logic [DIV_W-1:0]               tick_q, tick_d;
  logic                           stb_q, stb_d;
  logic [TRACKS-1:0]              trig_q, trig_d;
  logic [TRACKS-1:0][NSTEP-1:0]   pat_q, pat_d;

  logic              last_tick;
  logic              wrap;
  logic [STEP_W-1:0] step_nxt;
  logic              restart;
  logic              count;

  // len_i-1 wraps to all ones for len_i==0, giving the full length
  assign last_tick = (bus.div_i <= DIV_W'(1)) ||
                     (tick_q >= bus.div_i - DIV_W'(1));
  assign wrap      = step_q >= (bus.len_i - STEP_W'(1));
  assign step_nxt  = wrap ? '0 : step_q + STEP_W'(1);

  assign restart = bus.start_i && !bus.stop_i &&
                   (state_q != PAUSED);
  // the resume cycle counts as a run cycle; the pause cycle does not
  assign count = !bus.stop_i &&
                 (((state_q == RUN) && !bus.start_i && !bus.pause_i) ||
                  ((state_q == PAUSED) && (bus.start_i || bus.pause_i)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start_i && !bus.stop_i) state_d = RUN;
      end
      RUN: begin
        if (bus.stop_i)       state_d = IDLE;
        else if (bus.start_i) state_d = RUN;
        else if (bus.pause_i) state_d = PAUSED;
      end
      PAUSED: begin
        if (bus.stop_i)                       state_d = IDLE;
        else if (bus.start_i || bus.pause_i)  state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    step_d = step_q;
    tick_d = tick_q;
    stb_d  = 1'b0;
    if (bus.stop_i) begin
      step_d = '0;
      tick_d = '0;
    end else if (restart) begin
      step_d = '0;
      tick_d = '0;
      stb_d  = 1'b1;
    end else if (count) begin
      if (last_tick) begin
        tick_d = '0;
        step_d = step_nxt;
        stb_d  = 1'b1;
      end else begin
        tick_d = tick_q + DIV_W'(1);
      end
    end
  end

  // trigger reads the store before this cycle's write lands
  always_comb begin
    trig_d = '0;
    for (int t = 0; t < TRACKS; t++) begin
      trig_d[t] = stb_d && pat_q[t][step_d];
    end
  end

  always_comb begin
    pat_d = pat_q;
    if (bus.pat_we_i) begin
      for (int t = 0; t < TRACKS; t++) begin
        if (bus.pat_track_i == TW'(t)) begin
          pat_d[t][bus.pat_step_i] = bus.pat_val_i;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q <= '0;
      tick_q <= '0;
      stb_q  <= 1'b0;
      trig_q <= '0;
      pat_q  <= '0;
    end else begin
      step_q <= step_d;
      tick_q <= tick_d;
      stb_q  <= stb_d;
      trig_q <= trig_d;
      pat_q  <= pat_d;
    end
  end

  assign bus.step_o     = step_q;
  assign bus.step_stb_o = stb_q;
  assign bus.trig_o     = trig_q;
  assign bus.running_o  = (state_q != IDLE);
endmodule

// File: tb/tb_drum_step_sequencer.sv
// Scoreboard bench for drum_step_sequencer: a step-level reference
// model predicts each cycle's outputs, a monitor compares them.
module tb_drum_step_sequencer;
  localparam int TRACKS = 4;
  localparam int STEP_W = 4;
  localparam int DIV_W  = 24;
  localparam int NSTEP  = 16;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_PAUSE = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  drum_step_sequencer_if #(
    .TRACKS(TRACKS), .STEP_W(STEP_W), .DIV_W(DIV_W)
  ) bus ();

  drum_step_sequencer #(
    .TRACKS(TRACKS), .STEP_W(STEP_W), .DIV_W(DIV_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic       stb;
    logic [3:0] step;
    logic [3:0] trig;
    logic       run;
  } obs_t;

  obs_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  int m_mode;
  int m_pos;
  int m_el;
  bit m_pat[TRACKS][NSTEP];

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE;
    m_pos  = 0;
    m_el   = 0;
    for (int t = 0; t < TRACKS; t++)
      for (int s = 0; s < NSTEP; s++)
        m_pat[t][s] = 1'b0;
  endtask

  // one clock of the transport, stated as step/period rules
  task automatic model_step();
    obs_t e;
    bit   stb;
    bit   cnt;
    int   per;
    int   len;
    stb = 1'b0;
    cnt = 1'b0;
    if (bus.stop_i) begin
      m_mode = M_IDLE;
      m_pos  = 0;
      m_el   = 0;
    end else if (bus.start_i && m_mode != M_PAUSE) begin
      m_mode = M_RUN;
      m_pos  = 0;
      m_el   = 0;
      stb    = 1'b1;
    end else if (bus.start_i || bus.pause_i) begin
      if (m_mode == M_PAUSE) begin
        m_mode = M_RUN;
        cnt    = 1'b1;
      end else if (m_mode == M_RUN) begin
        m_mode = M_PAUSE;
      end
    end else if (m_mode == M_RUN) begin
      cnt = 1'b1;
    end
    if (cnt) begin
      per = (int'(bus.div_i) < 2) ? 1 : int'(bus.div_i);
      len = (bus.len_i == 0) ? NSTEP : int'(bus.len_i);
      m_el++;
      if (m_el >= per) begin
        m_el  = 0;
        m_pos = (m_pos + 1 >= len) ? 0 : m_pos + 1;
        stb   = 1'b1;
      end
    end
    e.stb  = stb;
    e.step = 4'(m_pos);
    e.run  = (m_mode != M_IDLE);
    for (int t = 0; t < TRACKS; t++)
      e.trig[t] = stb && m_pat[t][m_pos];
    sbq.push_back(e);
    if (bus.pat_we_i)
      m_pat[bus.pat_track_i][bus.pat_step_i] = bus.pat_val_i;
  endtask

  task automatic tick_cycle();
    model_step();
    @(posedge clk);
    #2;
    bus.start_i  = 1'b0;
    bus.stop_i   = 1'b0;
    bus.pause_i  = 1'b0;
    bus.pat_we_i = 1'b0;
  endtask

  task automatic run(int n);
    repeat (n) tick_cycle();
  endtask

  task automatic run_until(int pos, int el, string nm);
    int b;
    b = 0;
    while (!(m_mode == M_RUN && m_pos == pos && m_el == el)) begin
      tick_cycle();
      b++;
      if (b > 300) begin
        checks++;
        errors++;
        $display("FAIL %s timeout waiting step %0d", nm, pos);
        break;
      end
    end
  endtask

  task automatic write(int t, int s, bit v);
    bus.pat_we_i    = 1'b1;
    bus.pat_track_i = 2'(t);
    bus.pat_step_i  = 4'(s);
    bus.pat_val_i   = v;
    tick_cycle();
  endtask

  task automatic pulse_start();
    bus.start_i = 1'b1;
    tick_cycle();
  endtask

  task automatic pulse_stop();
    bus.stop_i = 1'b1;
    tick_cycle();
  endtask

  task automatic chk_zero(string nm);
    chk({nm, "_step"}, int'(bus.step_o), 0);
    chk({nm, "_stb"}, int'(bus.step_stb_o), 0);
    chk({nm, "_trig"}, int'(bus.trig_o), 0);
    chk({nm, "_run"}, int'(bus.running_o), 0);
  endtask

  always begin
    obs_t e;
    obs_t a;
    @(posedge clk);
    #1;
    if (rst_n && mon_en) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL sb_underflow at %0t", $time);
      end else begin
        e = sbq.pop_front();
        a.stb  = bus.step_stb_o;
        a.step = bus.step_o;
        a.trig = bus.trig_o;
        a.run  = bus.running_o;
        if (a !== e) begin
          errors++;
          $display("FAIL sb t=%0t got stb=%0b step=%0d trig=%b run=%0b want stb=%0b step=%0d trig=%b run=%0b",
                   $time, a.stb, a.step, a.trig, a.run,
                   e.stb, e.step, e.trig, e.run);
        end
      end
    end
  end

  initial begin
    int r;
    bus.start_i     = 1'b0;
    bus.stop_i      = 1'b0;
    bus.pause_i     = 1'b0;
    bus.div_i       = '0;
    bus.len_i       = '0;
    bus.pat_we_i    = 1'b0;
    bus.pat_track_i = '0;
    bus.pat_step_i  = '0;
    bus.pat_val_i   = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // basic play: track0 steps 0,2 and track1 step 3
    write(0, 0, 1'b1);
    write(0, 2, 1'b1);
    write(1, 3, 1'b1);
    bus.div_i = DIV_W'(4);
    bus.len_i = STEP_W'(4);
    pulse_start();
    run(22);

    // divider 0 and full-length pattern
    bus.div_i = '0;
    run(8);
    bus.div_i = DIV_W'(1);
    bus.len_i = '0;
    run(40);

    // shrink length below the current step
    pulse_stop();
    bus.div_i = DIV_W'(2);
    bus.len_i = STEP_W'(8);
    pulse_start();
    run_until(6, 0, "len_shrink");
    bus.len_i = STEP_W'(3);
    run(10);

    // pause 3 cycles into step 2, hold, resume with start
    pulse_stop();
    bus.div_i = DIV_W'(10);
    bus.len_i = '0;
    pulse_start();
    run_until(2, 3, "pause");
    bus.pause_i = 1'b1;
    tick_cycle();
    run(20);
    pulse_start();
    run(15);

    // stop wins over start; restart mid pattern
    bus.stop_i  = 1'b1;
    bus.start_i = 1'b1;
    tick_cycle();
    run(3);
    bus.div_i = DIV_W'(3);
    bus.len_i = STEP_W'(8);
    pulse_start();
    run_until(5, 1, "restart");
    pulse_start();
    run(6);

    // write landing on the step being triggered
    pulse_stop();
    bus.len_i = STEP_W'(4);
    pulse_start();
    run_until(0, 2, "collide");
    write(2, 1, 1'b1);
    run(14);

    // randomized controls, live div/len and pattern traffic
    pulse_start();
    repeat (400) begin
      r = $urandom_range(0, 99);
      bus.stop_i  = (r < 3);
      bus.start_i = (r >= 3 && r < 9) || (r >= 95);
      bus.pause_i = (r >= 9 && r < 14) || (r >= 97);
      if ($urandom_range(0, 19) == 0)
        bus.div_i = DIV_W'($urandom_range(0, 5));
      if ($urandom_range(0, 29) == 0)
        bus.len_i = STEP_W'($urandom_range(0, 15));
      bus.pat_we_i    = ($urandom_range(0, 3) == 0);
      bus.pat_track_i = 2'($urandom_range(0, 3));
      bus.pat_step_i  = 4'($urandom_range(0, 15));
      bus.pat_val_i   = 1'($urandom_range(0, 1));
      tick_cycle();
    end

    // asynchronous reset while running at step 5
    pulse_stop();
    bus.div_i = DIV_W'(2);
    bus.len_i = STEP_W'(8);
    write(3, 0, 1'b1);
    pulse_start();
    run_until(5, 0, "rst_mid");
    rst_n = 1'b0;
    #1;
    chk_zero("async_rst");
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    model_reset();
    pulse_start();
    run(5);

    pulse_stop();
    run(2);
    mon_en = 1'b0;
    @(posedge clk);
    #2;
    chk("sb_drain", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
